// File: rtl/ingress_deencap_pkg.sv
// ingress_deencap_pkg
//   Shared types and helpers for the ingress de-encapsulation stage.
//   - state_e    : packet FSM states (SKIP, FIRST, STREAM, FLUSH)
//   - sel_e      : realign datapath source select
//   - calc_skip_beats / calc_shift : split of the stripped header into whole
//                  bus beats and a residual byte offset
//   - keep_mask  : LSB-contiguous keep vector from a byte count (callers
//                  size-cast the result down to their bus width)
package ingress_deencap_pkg;

  localparam int MAX_BUS_BYTES = 128;

  typedef enum logic [1:0] {
    SKIP,
    FIRST,
    STREAM,
    FLUSH
  } state_e;

  typedef enum logic [1:0] {
    SEL_FIRST,  // current beat shifted down by SHIFT bytes
    SEL_MERGE,  // low bytes of current beat on top of the carry
    SEL_CARRY   // carry alone (tail of a packet)
  } sel_e;

  function automatic int calc_skip_beats(input int strip_bytes, input int bus_bytes);
    return strip_bytes / bus_bytes;
  endfunction

  function automatic int calc_shift(input int strip_bytes, input int bus_bytes);
    return strip_bytes % bus_bytes;
  endfunction

  function automatic logic [MAX_BUS_BYTES-1:0] keep_mask(input logic [31:0] nbytes);
    logic [MAX_BUS_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BUS_BYTES; i++) begin
      m[i] = (32'(i) < nbytes);
    end
    return m;
  endfunction

endpackage

// File: rtl/deencap_realign.sv
// deencap_realign
//   Byte-merge datapath: holds the carry (upper bytes of the previous beat)
//   and produces the realigned output data and keep for the selected source.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_sel        output source (SEL_FIRST / SEL_MERGE / SEL_CARRY)
//   i_load       capture bytes SHIFT..B-1 of i_data into the carry
//   i_data       current input beat
//   i_nbytes     number of valid bytes in i_data
//   o_data       realigned data
//   o_keep       LSB-contiguous keep for o_data
module deencap_realign
  import ingress_deencap_pkg::*;
#(
  parameter  int NUM_BUS_BYTES = 8,
  parameter  int SHIFT         = 2,
  localparam int DW            = NUM_BUS_BYTES * 8,
  localparam int CW            = $clog2(NUM_BUS_BYTES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  sel_e                     i_sel,
  input  logic                     i_load,
  input  logic [DW-1:0]            i_data,
  input  logic [CW-1:0]            i_nbytes,
  output logic [DW-1:0]            o_data,
  output logic [NUM_BUS_BYTES-1:0] o_keep
);

  logic [CW-1:0] w_count;

  generate
    if (SHIFT == 0) begin : g_passthru
      // Header ends on a beat boundary: payload is already aligned.
      assign o_data  = i_data;
      assign w_count = i_nbytes;
    end else begin : g_shift
      localparam int            CB      = NUM_BUS_BYTES - SHIFT;
      localparam logic [CW-1:0] SHIFT_N = CW'(SHIFT);
      localparam logic [CW-1:0] CB_N    = CW'(CB);

      logic [8*CB-1:0] r_carry_data;
      logic [CW-1:0]   r_carry_n;
      logic [CW-1:0]   w_tail_n;
      logic [CW-1:0]   w_lo_n;

      // Bytes above the boundary, and bytes below it (capped by n).
      assign w_tail_n = (i_nbytes > SHIFT_N) ? i_nbytes - SHIFT_N : '0;
      assign w_lo_n   = (i_nbytes > SHIFT_N) ? SHIFT_N : i_nbytes;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_carry_data <= '0;
          r_carry_n    <= '0;
        end else if (i_load) begin
          r_carry_data <= i_data[DW-1:8*SHIFT];
          r_carry_n    <= w_tail_n;
        end
      end

      always_comb begin
        o_data  = '0;
        w_count = '0;
        case (i_sel)
          SEL_FIRST: begin
            o_data  = DW'(i_data[DW-1:8*SHIFT]);
            w_count = w_tail_n;
          end
          SEL_MERGE: begin
            o_data  = {i_data[8*SHIFT-1:0], r_carry_data};
            w_count = CB_N + w_lo_n;
          end
          SEL_CARRY: begin
            o_data  = DW'(r_carry_data);
            w_count = r_carry_n;
          end
          default: ;
        endcase
      end
    end
  endgenerate

  assign o_keep = NUM_BUS_BYTES'(keep_mask(32'(w_count)));

endmodule

// File: rtl/ingress_deencap.sv
// ingress_deencap
//   Strips the fixed encapsulation header (STRIP_BYTES) from each packet of
//   the filter's routed stream and realigns the payload to byte 0. tdest and
//   the UDP-checksum flag are captured on beat 0 and held for the packet.
//   Packets with no payload are consumed and dropped.
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   axis_in_*                input AXI-Stream (tdata/tkeep/tlast/tdest)
//   has_udp_checksum_in      side channel, valid with the first beat
//   axis_out_*               realigned payload stream, single output register
//   has_udp_checksum_out     per-packet flag aligned with output beats
//   runt_count               dropped-runt counter
// Configuration:
//   INGRESS_DEENCAP_RUNT_CNT_EN  defined: saturating 32-bit runt counter;
//                                undefined: runt_count tied to 0.
module ingress_deencap
  import ingress_deencap_pkg::*;
#(
  parameter  int AXIS_BUS_WIDTH = 64,
  parameter  int AXIS_ID_WIDTH  = 4,
  parameter  int STRIP_BYTES    = 50,
  localparam int NUM_BUS_BYTES  = AXIS_BUS_WIDTH / 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic [NUM_BUS_BYTES-1:0]  axis_in_tkeep,
  input  logic                      axis_in_tlast,
  input  logic [AXIS_ID_WIDTH:0]    axis_in_tdest,
  input  logic                      axis_in_tvalid,
  output logic                      axis_in_tready,
  input  logic                      has_udp_checksum_in,
  output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
  output logic [NUM_BUS_BYTES-1:0]  axis_out_tkeep,
  output logic                      axis_out_tlast,
  output logic [AXIS_ID_WIDTH:0]    axis_out_tdest,
  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready,
  output logic                      has_udp_checksum_out,
  output logic [31:0]               runt_count
);

  localparam int SKIP_BEATS = calc_skip_beats(STRIP_BYTES, NUM_BUS_BYTES);
  localparam int SHIFT      = calc_shift(STRIP_BYTES, NUM_BUS_BYTES);
  localparam int CW         = $clog2(NUM_BUS_BYTES + 1);
  localparam int CNT_W      = (SKIP_BEATS > 1) ? $clog2(SKIP_BEATS) : 1;

  localparam logic [CW-1:0]    SHIFT_N     = CW'(SHIFT);
  localparam logic [CNT_W-1:0] LAST_SKIP   = CNT_W'((SKIP_BEATS > 0) ? SKIP_BEATS - 1 : 0);
  // With no whole header beats, every packet starts on its boundary beat.
  localparam state_e           START_STATE = (SKIP_BEATS == 0) ? FIRST : SKIP;

  state_e                    r_state;
  logic [CNT_W-1:0]          r_beat_cnt;
  logic                      r_run;
  logic [AXIS_ID_WIDTH:0]    r_pkt_tdest;
  logic                      r_pkt_udp;
  logic                      r_out_valid;
  logic [AXIS_BUS_WIDTH-1:0] r_out_data;
  logic [NUM_BUS_BYTES-1:0]  r_out_keep;
  logic                      r_out_last;
  logic [AXIS_ID_WIDTH:0]    r_out_tdest;
  logic                      r_out_udp;

  logic                      w_out_free;
  logic                      w_in_fire;
  logic [CW-1:0]             w_in_n;
  logic                      w_first_beat;
  logic [AXIS_ID_WIDTH:0]    w_tdest;
  logic                      w_udp;
  sel_e                      w_sel;
  logic                      w_load_carry;
  logic                      w_emit;
  logic                      w_emit_last;
  logic [AXIS_BUS_WIDTH-1:0] w_rl_data;
  logic [NUM_BUS_BYTES-1:0]  w_rl_keep;

  // r_run holds tready low while reset is asserted so every output reads 0.
  assign w_out_free     = !r_out_valid || axis_out_tready;
  assign axis_in_tready = r_run && (r_state != FLUSH) && w_out_free;
  assign w_in_fire      = axis_in_tvalid && axis_in_tready;
  assign w_in_n         = CW'($countones(axis_in_tkeep));

  assign w_first_beat = (SKIP_BEATS == 0) ? (r_state == FIRST)
                                          : (r_state == SKIP && r_beat_cnt == '0);
  // On beat 0 the capture register is not yet loaded, so use the bus directly.
  assign w_tdest = w_first_beat ? axis_in_tdest : r_pkt_tdest;
  assign w_udp   = w_first_beat ? has_udp_checksum_in : r_pkt_udp;

  always_comb begin
    w_sel        = SEL_FIRST;
    w_load_carry = 1'b0;
    w_emit       = 1'b0;
    w_emit_last  = 1'b0;
    case (r_state)
      FIRST: begin
        w_load_carry = w_in_fire && !axis_in_tlast;
        w_emit       = w_in_fire && (axis_in_tlast ? (w_in_n > SHIFT_N) : (SHIFT == 0));
        w_emit_last  = axis_in_tlast;
      end
      STREAM: begin
        w_sel        = (SHIFT == 0) ? SEL_FIRST : SEL_MERGE;
        w_load_carry = w_in_fire;
        w_emit       = w_in_fire;
        // A long last beat leaves bytes in the carry; its tail goes out in FLUSH.
        w_emit_last  = (SHIFT == 0) ? axis_in_tlast
                                    : (axis_in_tlast && (w_in_n <= SHIFT_N));
      end
      FLUSH: begin
        w_sel       = SEL_CARRY;
        w_emit      = w_out_free;
        w_emit_last = 1'b1;
      end
      default: ;
    endcase
  end

  deencap_realign #(
    .NUM_BUS_BYTES (NUM_BUS_BYTES),
    .SHIFT         (SHIFT)
  ) u_realign (
    .clk      (aclk),
    .rst_n    (aresetn),
    .i_sel    (w_sel),
    .i_load   (w_load_carry),
    .i_data   (axis_in_tdata),
    .i_nbytes (w_in_n),
    .o_data   (w_rl_data),
    .o_keep   (w_rl_keep)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= START_STATE;
      r_beat_cnt  <= '0;
      r_run       <= 1'b0;
      r_pkt_tdest <= '0;
      r_pkt_udp   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_tdest <= '0;
      r_out_udp   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_in_fire && w_first_beat) begin
        r_pkt_tdest <= axis_in_tdest;
        r_pkt_udp   <= has_udp_checksum_in;
      end
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rl_data;
        r_out_keep  <= w_rl_keep;
        r_out_last  <= w_emit_last;
        r_out_tdest <= w_tdest;
        r_out_udp   <= w_udp;
      end else if (axis_out_tready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        SKIP: begin
          if (w_in_fire) begin
            if (axis_in_tlast) begin
              r_beat_cnt <= '0;
            end else if (r_beat_cnt == LAST_SKIP) begin
              r_beat_cnt <= '0;
              r_state    <= FIRST;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        FIRST: begin
          if (w_in_fire) begin
            r_state <= axis_in_tlast ? START_STATE : STREAM;
          end
        end
        STREAM: begin
          if (w_in_fire && axis_in_tlast) begin
            r_state <= (SHIFT != 0 && w_in_n > SHIFT_N) ? FLUSH : START_STATE;
          end
        end
        FLUSH: begin
          if (w_out_free) begin
            r_state <= START_STATE;
          end
        end
        default: r_state <= START_STATE;
      endcase
    end
  end

`ifdef INGRESS_DEENCAP_RUNT_CNT_EN
  logic        w_runt;
  logic [31:0] r_runt_count;

  assign w_runt = w_in_fire && axis_in_tlast &&
                  ((r_state == SKIP) || (r_state == FIRST && w_in_n <= SHIFT_N));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_runt_count <= '0;
    end else if (w_runt && r_runt_count != '1) begin
      r_runt_count <= r_runt_count + 32'd1;
    end
  end

  assign runt_count = r_runt_count;
`else
  assign runt_count = '0;
`endif

  assign axis_out_tvalid      = r_out_valid;
  assign axis_out_tdata       = r_out_data;
  assign axis_out_tkeep       = r_out_keep;
  assign axis_out_tlast       = r_out_last;
  assign axis_out_tdest       = r_out_tdest;
  assign has_udp_checksum_out = r_out_udp;

endmodule

// File: tb/tb_ingress_deencap.sv
module tb_ingress_deencap;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] axis_in_tdata;
  logic [7:0]  axis_in_tkeep;
  logic        axis_in_tlast;
  logic [4:0]  axis_in_tdest;
  logic        axis_in_tvalid;
  logic        axis_in_tready;
  logic        has_udp_checksum_in;
  logic [63:0] axis_out_tdata;
  logic [7:0]  axis_out_tkeep;
  logic        axis_out_tlast;
  logic [4:0]  axis_out_tdest;
  logic        axis_out_tvalid;
  logic        axis_out_tready;
  logic        has_udp_checksum_out;
  logic [31:0] runt_count;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [4:0]  tdest;
    logic        udp;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   exp_runts  = 0;
  int   tready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  always #5 aclk = ~aclk;

  ingress_deencap dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .axis_in_tdata        (axis_in_tdata),
    .axis_in_tkeep        (axis_in_tkeep),
    .axis_in_tlast        (axis_in_tlast),
    .axis_in_tdest        (axis_in_tdest),
    .axis_in_tvalid       (axis_in_tvalid),
    .axis_in_tready       (axis_in_tready),
    .has_udp_checksum_in  (has_udp_checksum_in),
    .axis_out_tdata       (axis_out_tdata),
    .axis_out_tkeep       (axis_out_tkeep),
    .axis_out_tlast       (axis_out_tlast),
    .axis_out_tdest       (axis_out_tdest),
    .axis_out_tvalid      (axis_out_tvalid),
    .axis_out_tready      (axis_out_tready),
    .has_udp_checksum_out (has_udp_checksum_out),
    .runt_count           (runt_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input int idx, input int seed);
    return 8'((idx + seed) & 255);
  endfunction

  task automatic push_exp(input logic [63:0] data, input logic [7:0] keep, input logic last,
                          input logic [4:0] tdest, input logic udp);
    exp_t e;
    e.data = data; e.keep = keep; e.last = last; e.tdest = tdest; e.udp = udp;
    exp_q.push_back(e);
  endtask

  // Reference: payload is packet bytes 50..len-1, packed 8 per beat from byte 0.
  task automatic model_push(input int len, input int seed, input logic [4:0] tdest, input logic udp);
    logic [63:0] d;
    logic [7:0]  k;
    if (len <= 50) begin
      exp_runts++;
    end else begin
      for (int c = 50; c < len; c += 8) begin
        d = '0;
        k = '0;
        for (int j = 0; j < 8; j++) begin
          if (c + j < len) begin
            d[8*j +: 8] = pbyte(c + j, seed);
            k[j] = 1'b1;
          end
        end
        push_exp(d, k, (c + 8 >= len), tdest, udp);
      end
    end
  endtask

  // Drives one packet (or its first max_beats beats when max_beats > 0).
  // tdest/udp are only meaningful on beat 0, so later beats carry other values.
  task automatic send_pkt(input int len, input int seed, input logic [4:0] tdest, input logic udp,
                          input int max_beats, input bit flush_chk);
    int nb;
    bit acc;
    int t;
    nb = (len + 7) / 8;
    if (max_beats > 0 && max_beats < nb) nb = max_beats;
    for (int k = 0; k < nb; k++) begin
      axis_in_tdata = '0;
      axis_in_tkeep = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*k + j < len) begin
          axis_in_tdata[8*j +: 8] = pbyte(8*k + j, seed);
          axis_in_tkeep[j] = 1'b1;
        end
      end
      axis_in_tlast       = (8*k + 8 >= len);
      axis_in_tdest       = (k == 0) ? tdest : ~tdest;
      has_udp_checksum_in = (k == 0) ? udp : 1'b0;
      axis_in_tvalid      = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 1000) begin
        @(negedge aclk);
        acc = axis_in_tready;
        @(posedge aclk);
        #1;
        t++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat %0d of %0d-byte packet not accepted", k, len);
      end
    end
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
    if (flush_chk) begin
      @(negedge aclk);
      check("flush_in_tready", 64'(axis_in_tready), 64'd0);
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) begin
      @(posedge aclk);
      #1;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic check_runts();
`ifdef INGRESS_DEENCAP_RUNT_CNT_EN
    check("runt_count", 64'(runt_count), 64'(exp_runts));
`else
    check("runt_count", 64'(runt_count), 64'd0);
`endif
  endtask

  // Output-ready driver.
  initial begin
    axis_out_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (tready_mode)
        0:       axis_out_tready = 1'b0;
        1:       axis_out_tready = 1'b1;
        default: axis_out_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops one expected beat per output handshake.
  always @(negedge aclk) begin : monitor
    exp_t        e;
    logic [63:0] m;
    if (aresetn && axis_out_tvalid && axis_out_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h, required no beat",
                 axis_out_tdata, axis_out_tkeep);
      end else begin
        e = exp_q.pop_front();
        for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{e.keep[j]}};
        check("out_data",  axis_out_tdata & m, e.data);
        check("out_keep",  64'(axis_out_tkeep), 64'(e.keep));
        check("out_last",  64'(axis_out_tlast), 64'(e.last));
        check("out_tdest", 64'(axis_out_tdest), 64'(e.tdest));
        check("out_udp",   64'(has_udp_checksum_out), 64'(e.udp));
        $display("beat data=0x%016h keep=0x%02h last=%0d tdest=%0d udp=%0d",
                 axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tdest,
                 has_udp_checksum_out);
      end
    end
  end

  initial begin
    aresetn             = 1'b0;
    axis_in_tdata       = '0;
    axis_in_tkeep       = '0;
    axis_in_tlast       = 1'b0;
    axis_in_tdest       = '0;
    axis_in_tvalid      = 1'b0;
    has_udp_checksum_in = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid",   64'(axis_out_tvalid), 64'd0);
    check("rst_tdata",    axis_out_tdata, 64'd0);
    check("rst_tkeep",    64'(axis_out_tkeep), 64'd0);
    check("rst_tlast",    64'(axis_out_tlast), 64'd0);
    check("rst_tdest",    64'(axis_out_tdest), 64'd0);
    check("rst_udp",      64'(has_udp_checksum_out), 64'd0);
    check("rst_in_ready", 64'(axis_in_tready), 64'd0);
    check("rst_runts",    64'(runt_count), 64'd0);
    aresetn = 1'b1;

    // 64-byte packet: payload bytes 50..63 with byte value = index.
    push_exp(64'h3938373635343332, 8'hFF, 1'b0, 5'd1, 1'b0);
    push_exp(64'h00003F3E3D3C3B3A, 8'h3F, 1'b1, 5'd1, 1'b0);
    send_pkt(64, 0, 5'd1, 1'b0, 0, 1'b0);
    drain();

    // 50-byte runt: nothing emitted.
    model_push(50, 16, 5'd2, 1'b1);
    send_pkt(50, 16, 5'd2, 1'b1, 0, 1'b0);
    drain();
    check_runts();

    // 51-byte packet: single byte (50 + 0x40).
    push_exp(64'h72, 8'h01, 1'b1, 5'd3, 1'b1);
    send_pkt(51, 64, 5'd3, 1'b1, 0, 1'b0);
    drain();

    // 60-byte packet: full beat then a 2-byte FLUSH beat; tready low in FLUSH.
    push_exp(64'h403F3E3D3C3B3A39, 8'hFF, 1'b0, 5'd5, 1'b0);
    push_exp(64'h0000000000004241, 8'h03, 1'b1, 5'd5, 1'b0);
    send_pkt(60, 7, 5'd5, 1'b0, 0, 1'b1);
    drain();

    // Back-to-back packets under random output backpressure.
    tready_mode = 2;
    model_push(64, 33, 5'd2, 1'b1);   send_pkt(64, 33, 5'd2, 1'b1, 0, 1'b0);
    model_push(51, 51, 5'd6, 1'b0);   send_pkt(51, 51, 5'd6, 1'b0, 0, 1'b0);
    model_push(50, 85, 5'd4, 1'b1);   send_pkt(50, 85, 5'd4, 1'b1, 0, 1'b0);
    model_push(57, 10, 5'd7, 1'b0);   send_pkt(57, 10, 5'd7, 1'b0, 0, 1'b0);
    model_push(100, 128, 5'h11, 1'b1); send_pkt(100, 128, 5'h11, 1'b1, 0, 1'b0);
    model_push(64, 195, 5'd0, 1'b0);  send_pkt(64, 195, 5'd0, 1'b0, 0, 1'b0);
    drain();
    tready_mode = 1;
    check_runts();

    // Reset in the middle of a packet with an output beat pending.
    tready_mode = 0;
    send_pkt(80, 3, 5'd8, 1'b1, 8, 1'b0);
    check("pre_reset_tvalid", 64'(axis_out_tvalid), 64'd1);
    #2;
    aresetn = 1'b0;
    exp_runts = 0;
    #1;
    check("mid_rst_tvalid", 64'(axis_out_tvalid), 64'd0);
    check("mid_rst_tdata",  axis_out_tdata, 64'd0);
    check("mid_rst_tdest",  64'(axis_out_tdest), 64'd0);
    check("mid_rst_runts",  64'(runt_count), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tready_mode = 1;
    model_push(51, 97, 5'd9, 1'b1);  send_pkt(51, 97, 5'd9, 1'b1, 0, 1'b0);
    model_push(64, 25, 5'd12, 1'b0); send_pkt(64, 25, 5'd12, 1'b0, 0, 1'b0);
    drain();
    check_runts();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ingress_deencap.md
Name: ingress_deencap

Overview:
- Stage directly downstream of the ingress filter; consumes its routed stream (tdata/tkeep/tlast/tdest plus has_udp_checksum side channel).
- Strips the fixed-length encapsulation header (Ethernet+IPv4+UDP+VSID) from every packet and re-aligns the payload to byte 0 of the bus.
- Forwards tdest and the UDP-checksum flag, held constant per packet, to the per-tenant egress.
- Packets with no payload (runts) are consumed and dropped.

Parameters:
AXIS_BUS_WIDTH, 64, data width in bits; multiple of 8; NUM_BUS_BYTES=AXIS_BUS_WIDTH/8.
AXIS_ID_WIDTH, 4, tdest width is AXIS_ID_WIDTH+1.
STRIP_BYTES, 50, header bytes removed; must be ≥1. Derived: SKIP_BEATS=STRIP_BYTES/NUM_BUS_BYTES, SHIFT=STRIP_BYTES%NUM_BUS_BYTES.

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous assert, active-low
axis_in_tdata  in  AXIS_BUS_WIDTH  input data
axis_in_tkeep  in  NUM_BUS_BYTES  LSB-contiguous; all ones except on the tlast beat
axis_in_tlast  in  1  end of packet
axis_in_tdest  in  AXIS_ID_WIDTH+1  destination from the filter
axis_in_tvalid  in  1  valid
axis_in_tready  out  1  ready
has_udp_checksum_in  in  1  side channel, valid with the first beat
axis_out_tdata  out  AXIS_BUS_WIDTH  realigned payload
axis_out_tkeep  out  NUM_BUS_BYTES  LSB-contiguous
axis_out_tlast  out  1  end of payload
axis_out_tdest  out  AXIS_ID_WIDTH+1  per-packet destination
axis_out_tvalid  out  1  valid
axis_out_tready  in  1  ready
has_udp_checksum_out  out  1  per-packet flag, aligned with the output beats
runt_count  out  32  count of dropped runt packets (see Optional Feature)

Behaviour:
- Reset (async, aresetn=0):
  - All outputs 0, including tvalid, tdest and runt_count.
  - FSM returns to SKIP; beat counter and carry register are cleared.
  - A packet in flight is abandoned, with no partial output.
  - After release, the block resynchronises on the next beat, which is treated as a first beat.
- Output register: single stage. axis_in_tready = !out_valid || axis_out_tready, except in FLUSH, where tready=0.
- Latency: one cycle from the input beat that completes an output beat to axis_out_tvalid.
- Per-packet capture: tdest and has_udp_checksum are sampled on beat 0 and held on every output beat of that packet.
- FSM:
  - SKIP:
    - Counts accepted beats 0..SKIP_BEATS-1 and discards them.
    - tlast seen in SKIP means a runt: drop it and stay in SKIP.
    - After SKIP_BEATS beats, go to FIRST. If SKIP_BEATS=0, the packet starts in FIRST.
  - FIRST: the beat carrying the header/payload boundary. Let n = valid bytes.
    - tlast with n≤SHIFT: runt, drop, go to SKIP.
    - tlast with n>SHIFT: emit one beat (bytes SHIFT..n-1 at position 0, keep of n-SHIFT ones, tlast=1), go to SKIP.
    - Not tlast, SHIFT=0: emit the full beat, go to STREAM.
    - Not tlast, SHIFT≠0: load carry with bytes SHIFT..B-1 (B-SHIFT bytes), emit nothing, go to STREAM.
  - STREAM, SHIFT≠0: each accepted beat (n bytes) emits {low min(n,SHIFT) bytes, carry}; the carry reloads with bytes SHIFT..B-1.
    - tlast with n≤SHIFT: emit with keep B-SHIFT+n and tlast=1, go to SKIP.
    - tlast with n>SHIFT: emit a full beat with tlast=0, go to FLUSH.
  - STREAM, SHIFT=0: pass-through. tlast returns to SKIP.
  - FLUSH: emit the carry, n-SHIFT bytes, with tlast=1 once the output register is free; then go to SKIP.
- Simultaneous pop and load of the output register is legal: full throughput with no bubbles except the FIRST-load and FLUSH cycles.
- tdest MSB set (error route) is not expected; such a packet is passed through unchanged in routing.

Optional Feature:
- Macro INGRESS_DEENCAP_RUNT_CNT_EN.
- Defined: runt_count increments by 1, saturating at 2^32-1, in the cycle each runt tlast is accepted.
- Undefined: no counter logic; runt_count is tied to 0. Runt dropping is unchanged.

Decomposition:
- Package ingress_deencap_pkg holds the state enum (SKIP, FIRST, STREAM, FLUSH) and functions computing SKIP_BEATS, SHIFT and the keep mask from a byte count.
- Sub-module deencap_realign holds the carry register and the byte-merge/keep datapath. The FSM and output register stay in the top level.

Test Plan:
- 64-byte packet, B=8, STRIP=50, beats 0..7 full keep → two output beats: {in7[1:0],in6[7:2]} keep 0xFF tlast=0, then in7[7:2] keep 0x3F tlast=1.
- 50-byte packet (last beat keep 0x03) → no output; runt_count=1 with the macro, 0 without.
- 51-byte packet, tdest=3, has_udp_checksum_in=1 → one beat, byte in6[2], keep 0x01, tlast=1, tdest=3, has_udp_checksum_out=1.
- 60-byte packet (last keep 0x0F, n=4>SHIFT) → beat {in7[1:0],in6[7:2]} keep 0xFF, then FLUSH beat in7[3:2] keep 0x03 tlast=1; axis_in_tready=0 during FLUSH.
- Random axis_out_tready toggling over back-to-back 64/51/50-byte packets → output byte stream matches the model, no data loss or duplication.
- aresetn asserted mid-STREAM → outputs 0 immediately; the next packet after release is decapsulated correctly.
